width_gearbox: RTL and testbench



---
 rtl/gearbox_pkg.sv | 14 +
 rtl/gearbox_buf.sv | 69 ++++++
 rtl/width_gearbox.sv | 128 ++++++++++++
 tb/tb_width_gearbox.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gearbox_pkg.sv
// Shared types and helpers for the width gearbox.
package gearbox_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Width of a counter that must represent every value 0..buf_w inclusive.
  function automatic int cnt_w(input int buf_w);
    return $clog2(buf_w + 1);
  endfunction

endpackage

// File: rtl/gearbox_buf.sv
// Left-aligned bit buffer for the gearbox. It appends an input beat just
// below the valid bits, exposes the top OUT_W bits of the combined buffer,
// and shifts the remainder up to the MSB when a word is taken.
module gearbox_buf
  import gearbox_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 12,
  localparam int BUF_W = IN_W + OUT_W,
  localparam int CW    = cnt_w(BUF_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,   // append data_i this cycle (only when cnt_o <= OUT_W)
  input  logic [IN_W-1:0]  data_i,
  input  logic             pop_i,    // remove top OUT_W bits of the combined buffer
  input  logic             clear_i,  // discard everything (after the padded final word)
  output logic [CW-1:0]    cnt_o,    // registered fill count
  output logic [CW-1:0]    n_o,      // fill count including this cycle's beat
  output logic [OUT_W-1:0] top_o     // top OUT_W bits of the combined buffer
);

  localparam logic [CW-1:0] IN_WC  = CW'(IN_W);
  localparam logic [CW-1:0] OUT_WC = CW'(OUT_W);

  logic [BUF_W-1:0] buf_q, buf_d, comb_buf;
  logic [CW-1:0]    cnt_q, cnt_d, n;

  // Combined buffer: old bits plus the accepted beat placed right below them.
  // Bits below the fill count are always zero, so OR-ing is enough, and a
  // short final word comes out already zero-padded.
  always_comb begin
    comb_buf = buf_q;
    n        = cnt_q;
    if (push_i) begin
      comb_buf = buf_q | ({data_i, {OUT_W{1'b0}}} >> cnt_q);
      n        = cnt_q + IN_WC;
    end
  end

  // Next buffer contents: clear, take a word off the top, or just keep the append.
  always_comb begin
    buf_d = comb_buf;
    cnt_d = n;
    if (clear_i) begin
      buf_d = '0;
      cnt_d = '0;
    end else if (pop_i) begin
      buf_d = comb_buf << OUT_W;
      cnt_d = n - OUT_WC;
    end
  end

  // Buffer and fill-count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign n_o   = n;
  assign top_o = comb_buf[BUF_W-1 -: OUT_W];

endmodule

// File: rtl/width_gearbox.sv
// Repacks IN_W-bit beats into OUT_W-bit words, MSB first, with valid/ready
// on both sides, packet framing via last, and a zero-padded final word.
module width_gearbox
  import gearbox_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [IN_W-1:0]  data_in,
  input  logic             last_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [OUT_W-1:0] data_out,
  output logic             last_out
);

  localparam int BUF_W = IN_W + OUT_W;
  localparam int CW    = cnt_w(BUF_W);
  localparam logic [CW-1:0] OUT_WC = CW'(OUT_W);

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [OUT_W-1:0] data_q, data_d;

  logic             accept, slot_free, full, pop, clear;
  logic [CW-1:0]    cnt, n;
  logic [OUT_W-1:0] top;

  // Registers only (plus reset), so no combinational path from valid_in/ready_out.
  // Accepting only while cnt <= OUT_W guarantees the beat always fits.
  assign ready_in  = !rst && (state_q == FILL) && (cnt <= OUT_WC);
  assign accept    = valid_in && ready_in;
  assign slot_free = !valid_q || ready_out;
  assign full      = (n >= OUT_WC);

  gearbox_buf #(
    .IN_W (IN_W),
    .OUT_W(OUT_W)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .push_i (accept),
    .data_i (data_in),
    .pop_i  (pop),
    .clear_i(clear),
    .cnt_o  (cnt),
    .n_o    (n),
    .top_o  (top)
  );

  // Next-state, pop decision and output-register update.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    pop     = 1'b0;
    clear   = 1'b0;

    if (slot_free) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
      if (full) begin
        pop     = 1'b1;
        valid_d = 1'b1;
        data_d  = top;
      end
    end

    unique case (state_q)
      FILL: begin
        if (accept && last_in) begin
          // A packet ending exactly on a word boundary closes in this very pop.
          if (pop && (n == OUT_WC)) begin
            last_d = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (slot_free) begin
          if (full) begin
            if (n == OUT_WC) begin
              last_d  = 1'b1;
              state_d = FILL;
            end
          end else if (n != '0) begin
            // Short tail: top bits are already zero below the fill count.
            clear   = 1'b1;
            valid_d = 1'b1;
            data_d  = top;
            last_d  = 1'b1;
            state_d = FILL;
          end else begin
            state_d = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State and registered output word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign last_out  = last_q;

endmodule

// File: tb/tb_width_gearbox.sv
// Self-checking bench for width_gearbox: directed cases on 8->12 and 12->8,
// then randomized traffic on 8/12, 12/8, 5/7 and 16/16 against a bit-queue model.
module tb_width_gearbox;

  localparam int NI = 4;

  function automatic int iw_of(input int k);
    case (k)
      0: return 8;
      1: return 12;
      2: return 5;
      default: return 16;
    endcase
  endfunction

  function automatic int ow_of(input int k);
    case (k)
      0: return 12;
      1: return 8;
      2: return 7;
      default: return 16;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NI-1:0] vin  = '0;
  logic [NI-1:0] lin  = '0;
  logic [NI-1:0] rout = '0;
  logic [63:0]   din [NI];
  logic [NI-1:0] rin;
  logic [NI-1:0] vout;
  logic [NI-1:0] lout;
  logic [NI*64-1:0] dout_flat;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int IW = iw_of(gi);
    localparam int OW = ow_of(gi);
    logic [OW-1:0] dq;
    width_gearbox #(.IN_W(IW), .OUT_W(OW)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .valid_in (vin[gi]),
      .ready_in (rin[gi]),
      .data_in  (din[gi][IW-1:0]),
      .last_in  (lin[gi]),
      .valid_out(vout[gi]),
      .ready_out(rout[gi]),
      .data_out (dq),
      .last_out (lout[gi])
    );
    assign dout_flat[gi*64 +: 64] = 64'(dq);
  end

  function automatic logic [63:0] dout_of(input int k);
    return dout_flat[k*64 +: 64];
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: stream bits of the current packet plus expected words.
  bit          bitq  [$];
  logic [63:0] exp_w [$];
  bit          exp_l [$];

  // Back-pressure stability tracking.
  bit          hold_q = 1'b0;
  logic [63:0] hold_d = '0;
  bit          hold_l = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Append a beat MSB first; cut whole words; close the packet on last.
  task automatic model_accept(input int k, input logic [63:0] d, input bit l);
    int iw = iw_of(k);
    int ow = ow_of(k);
    logic [63:0] w;
    for (int b = iw - 1; b >= 0; b--) bitq.push_back(d[b]);
    while (bitq.size() >= ow) begin
      w = '0;
      for (int b = 0; b < ow; b++) w = {w[62:0], bitq.pop_front()};
      exp_w.push_back(w);
      exp_l.push_back(1'b0);
    end
    if (l) begin
      if (bitq.size() == 0) begin
        exp_l[exp_l.size() - 1] = 1'b1;
      end else begin
        w = '0;
        for (int b = 0; b < ow; b++) begin
          w = {w[62:0], 1'b0};
          if (bitq.size() > 0) w[0] = bitq.pop_front();
        end
        exp_w.push_back(w);
        exp_l.push_back(1'b1);
      end
    end
  endtask

  // One clock: drive inputs at the falling edge, score any handshake, advance.
  task automatic tick(input int k, input bit v, input logic [63:0] d, input bit l,
                      input bit r, output bit acc);
    logic [63:0] w;
    bit wl;
    vin = '0; lin = '0; rout = '0;
    vin[k] = v; din[k] = d; lin[k] = l; rout[k] = r;
    if (hold_q) begin
      chk("hold valid_out", 64'(vout[k]), 64'd1);
      chk("hold data_out", dout_of(k), hold_d);
      chk("hold last_out", 64'(lout[k]), 64'(hold_l));
    end
    if (vout[k] && r) begin
      if (exp_w.size() == 0) begin
        chk("spurious word", 64'(vout[k]), 64'd0);
      end else begin
        w  = exp_w.pop_front();
        wl = exp_l.pop_front();
        chk("word data", dout_of(k), w);
        chk("word last", 64'(lout[k]), 64'(wl));
        $display("inst %0d word data=0x%0h last=%0d (expected 0x%0h last=%0d)",
                 k, dout_of(k), lout[k], w, wl);
      end
    end
    hold_q = vout[k] && !r;
    hold_d = dout_of(k);
    hold_l = lout[k];
    acc = v && rin[k];
    if (acc) model_accept(k, d, l);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vin = '0; lin = '0; rout = '0;
    bitq.delete(); exp_w.delete(); exp_l.delete();
    hold_q = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("reset valid_out", 64'(vout[k]), 64'd0);
      chk("reset data_out", dout_of(k), 64'd0);
      chk("reset last_out", 64'(lout[k]), 64'd0);
      chk("reset ready_in", 64'(rin[k]), 64'd0);
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) chk("ready_in after reset", 64'(rin[k]), 64'd1);
  endtask

  task automatic expect_word(input int k, input string tag, input logic [63:0] d, input bit l);
    chk({tag, " valid"}, 64'(vout[k]), 64'd1);
    chk({tag, " data"}, dout_of(k), d);
    chk({tag, " last"}, 64'(lout[k]), 64'(l));
  endtask

  task automatic expect_idle(input int k, input string tag);
    chk({tag, " idle"}, 64'(vout[k]), 64'd0);
  endtask

  task automatic drain(input int k);
    bit acc;
    int g = 0;
    while ((exp_w.size() > 0 || vout[k]) && g < 300) begin
      tick(k, 1'b0, 64'd0, 1'b0, 1'b1, acc);
      g++;
    end
    chk("drain model empty", 64'(exp_w.size()), 64'd0);
    chk("drain valid_out", 64'(vout[k]), 64'd0);
  endtask

  // Random source that holds each beat until accepted; final beat carries last.
  task automatic run_random(input int k, input int nbeats, input int pv, input int pr,
                            input int plast);
    logic [63:0] d;
    bit l, v, acc;
    int sent = 0;
    int guard = 0;
    d = {$urandom(), $urandom()};
    l = (nbeats == 1) || ($urandom_range(99) < plast);
    v = 1'b0;
    while (sent < nbeats && guard < 20 * nbeats + 100) begin
      if (!v) v = ($urandom_range(99) < pv);
      tick(k, v, d, l, ($urandom_range(99) < pr), acc);
      guard++;
      if (acc) begin
        sent++;
        v = 1'b0;
        d = {$urandom(), $urandom()};
        l = (sent == nbeats - 1) || ($urandom_range(99) < plast);
      end
    end
    chk("beats sent in budget", 64'(sent), 64'(nbeats));
    drain(k);
  endtask

  initial begin
    #600000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    bit seen_low;
    logic [63:0] pd;
    int g;

    for (int k = 0; k < NI; k++) din[k] = '0;
    @(negedge clk);

    // 8->12: packet of three beats ends on a word boundary, no pad word.
    do_reset();
    tick(0, 1'b1, 64'hA1, 1'b0, 1'b1, acc);
    expect_idle(0, "t1 after beat1");
    tick(0, 1'b1, 64'hB2, 1'b0, 1'b1, acc);
    expect_word(0, "t1 word0", 64'hA1B, 1'b0);
    tick(0, 1'b1, 64'hC3, 1'b1, 1'b1, acc);
    expect_word(0, "t1 word1", 64'h2C3, 1'b1);
    tick(0, 1'b0, 64'd0, 1'b0, 1'b1, acc);
    expect_idle(0, "t1 no pad");
    chk("t1 ready_in", 64'(rin[0]), 64'd1);

    // 8->12: two-beat packet leaves 4 bits, flushed as a padded last word.
    do_reset();
    tick(0, 1'b1, 64'hA1, 1'b0, 1'b1, acc);
    tick(0, 1'b1, 64'hB2, 1'b1, 1'b1, acc);
    expect_word(0, "t2 word0", 64'hA1B, 1'b0);
    chk("t2 ready_in in drain", 64'(rin[0]), 64'd0);
    tick(0, 1'b0, 64'd0, 1'b0, 1'b1, acc);
    expect_word(0, "t2 pad", 64'h200, 1'b1);
    chk("t2 ready_in after pad", 64'(rin[0]), 64'd1);
    tick(0, 1'b0, 64'd0, 1'b0, 1'b1, acc);
    expect_idle(0, "t2 end");

    // 12->8: one beat drains as two words on consecutive cycles.
    do_reset();
    tick(1, 1'b1, 64'hABC, 1'b1, 1'b1, acc);
    expect_word(1, "t4 word0", 64'hAB, 1'b0);
    chk("t4 ready_in in drain", 64'(rin[1]), 64'd0);
    tick(1, 1'b0, 64'd0, 1'b0, 1'b1, acc);
    expect_word(1, "t4 word1", 64'hC0, 1'b1);
    tick(1, 1'b0, 64'd0, 1'b0, 1'b1, acc);
    expect_idle(1, "t4 end");
    chk("t4 ready_in", 64'(rin[1]), 64'd1);

    // Reset mid-packet discards the buffered beat.
    do_reset();
    tick(0, 1'b1, 64'hA1, 1'b0, 1'b1, acc);
    do_reset();
    expect_idle(0, "t5 after reset");
    tick(0, 1'b1, 64'h11, 1'b0, 1'b1, acc);
    expect_idle(0, "t5 beat1");
    tick(0, 1'b1, 64'h22, 1'b0, 1'b1, acc);
    expect_word(0, "t5 word0", 64'h112, 1'b0);
    tick(0, 1'b1, 64'h33, 1'b1, 1'b1, acc);
    expect_word(0, "t5 word1", 64'h233, 1'b1);
    tick(0, 1'b0, 64'd0, 1'b0, 1'b1, acc);
    expect_idle(0, "t5 end");

    // 8->12 back-pressure: sink stalled for 10 cycles under continuous input.
    do_reset();
    seen_low = 1'b0;
    pd = 64'($urandom());
    for (int c = 0; c < 10; c++) begin
      tick(0, 1'b1, pd, 1'b0, 1'b0, acc);
      if (acc) pd = 64'($urandom());
      if (!rin[0]) seen_low = 1'b1;
    end
    chk("t3 ready_in dropped", 64'(seen_low), 64'd1);
    chk("t3 valid held", 64'(vout[0]), 64'd1);
    if (exp_w.size() > 0) chk("t3 first word held", dout_of(0), exp_w[0]);
    g = 0;
    acc = 1'b0;
    while (!acc && g < 10) begin
      tick(0, 1'b1, pd, 1'b0, 1'b1, acc);
      g++;
    end
    chk("t3 held beat accepted", 64'(acc), 64'd1);
    run_random(0, 12, 100, 100, 0);

    // Randomized traffic on every width pair.
    for (int k = 0; k < NI; k++) begin
      do_reset();
      run_random(k, 150, 70, 60, 15);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
